splitmix64_prng: RTL and testbench

- 64-bit SplitMix64 pseudo-random number generator.
- Seeded from `data_in` during reset. Each enabled cycle advances a Weyl-sequence state and drives the mixed (finalized) value on `out`.
- Used as a lightweight stimulus/randomization source; no cryptographic strength.

---
 rtl/splitmix64_pkg.sv | 35 +++
 rtl/splitmix64_prng_if.sv | 11 +
 rtl/splitmix64_mix.sv | 14 +
 rtl/splitmix64_prng.sv | 63 ++++++
 tb/tb_splitmix64_prng.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/splitmix64_pkg.sv
// Shared constants, word type and finalizer stage functions for the SplitMix64 generator.
package splitmix64_pkg;

   localparam int unsigned WORD_W = 64;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t GAMMA = 64'h9E3779B97F4A7C15;
   localparam word_t M1    = 64'hBF58476D1CE4E5B9;
   localparam word_t M2    = 64'h94D049BB133111EB;

   localparam int unsigned SH1 = 30;
   localparam int unsigned SH2 = 27;
   localparam int unsigned SH3 = 31;

   // First xor-shift-multiply; product keeps the low 64 bits.
   function automatic word_t mix_stage1(input word_t z);
      word_t t;
      t = z ^ (z >> SH1);
      return t * M1;
   endfunction

   // Second xor-shift-multiply; product keeps the low 64 bits.
   function automatic word_t mix_stage2(input word_t z);
      word_t t;
      t = z ^ (z >> SH2);
      return t * M2;
   endfunction

   // Final xor-shift.
   function automatic word_t mix_stage3(input word_t z);
      return z ^ (z >> SH3);
   endfunction

endpackage

// File: rtl/splitmix64_prng_if.sv
// Control/data bundle between a consumer and the SplitMix64 generator.
interface splitmix64_prng_if;

   logic                   en;
   splitmix64_pkg::word_t  data_in;
   splitmix64_pkg::word_t  out;

   modport master (output en, output data_in, input out);
   modport slave  (input en, input data_in, output out);

endinterface

// File: rtl/splitmix64_mix.sv
// Purely combinational SplitMix64 finalizer built from the package stage functions.
module splitmix64_mix
   import splitmix64_pkg::*;
(
   input  word_t z,
   output word_t result
);

   // Chain all three stages in one cycle.
   always_comb begin
      result = mix_stage3(mix_stage2(mix_stage1(z)));
   end

endmodule

// File: rtl/splitmix64_prng.sv
// SplitMix64 pseudo-random generator: Weyl-sequence state plus registered finalizer.
// Optional macro SPLITMIX64_PIPE_EN splits the finalizer into 3 enabled register
// stages; output values are unchanged, only delayed by two extra enabled cycles.
module splitmix64_prng
   import splitmix64_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   splitmix64_prng_if.slave   bus
);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH-1:0] out_r;

   assign next_state = state + GAMMA;
   assign bus.out    = out_r;

`ifdef SPLITMIX64_PIPE_EN

   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] stage2;

   // Seed/advance state and shift the finalizer pipeline; stages move only with en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= bus.data_in;
         stage1 <= '0;
         stage2 <= '0;
         out_r  <= '0;
      end else if (bus.en) begin
         state  <= next_state;
         stage1 <= mix_stage1(next_state);
         stage2 <= mix_stage2(stage1);
         out_r  <= mix_stage3(stage2);
      end
   end

`else

   logic [WIDTH-1:0] mixed;

   splitmix64_mix u_mix (
      .z      (next_state),
      .result (mixed)
   );

   // Seed on reset, otherwise advance state and register its mix when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= bus.data_in;
         out_r <= '0;
      end else if (bus.en) begin
         state <= next_state;
         out_r <= mixed;
      end
   end

`endif

endmodule

// File: tb/tb_splitmix64_prng.sv
// Self-checking bench for splitmix64_prng with an expected-output queue.
module tb_splitmix64_prng;
   import splitmix64_pkg::*;

`ifdef SPLITMIX64_PIPE_EN
   localparam int unsigned PIPE_ZEROS = 2;
`else
   localparam int unsigned PIPE_ZEROS = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   splitmix64_prng_if bus ();

   splitmix64_prng #(.WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   word_t exp_q[$];
   word_t ref_state;
   word_t last_out;

   function automatic word_t ref_mix(input word_t z);
      word_t a, b;
      a = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
      b = (a ^ (a >> 27)) * 64'h94D049BB133111EB;
      return b ^ (b >> 31);
   endfunction

   task automatic do_reset(input word_t seed, input logic en_during);
      rst         = 1'b1;
      bus.en      = en_during;
      bus.data_in = seed;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      bus.en      = 1'b0;
      bus.data_in = $urandom();
      ref_state   = seed;
      last_out    = '0;
      exp_q.delete();
      for (int unsigned i = 0; i < PIPE_ZEROS; i++) exp_q.push_back('0);
      total++;
      if (bus.out !== 64'h0) $display("FAIL reset_out: out=%h expected=%h", bus.out, 64'h0);
      else passed++;
      total++;
      if (dut.state !== seed) $display("FAIL reset_state: state=%h expected=%h", dut.state, seed);
      else passed++;
   endtask

   task automatic advance(input bit use_model, input string tag);
      word_t e;
      bus.en = 1'b1;
      @(posedge clk);
      #1;
      bus.en    = 1'b0;
      ref_state = ref_state + GAMMA;
      if (use_model) exp_q.push_back(ref_mix(ref_state));
      total++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: out=%h but no expected value queued", tag, bus.out);
      end else begin
         e = exp_q.pop_front();
         last_out = e;
         if (bus.out !== e) $display("FAIL %s: out=%h expected=%h", tag, bus.out, e);
         else passed++;
      end
   endtask

   task automatic hold(input int unsigned n);
      bus.en = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.out !== last_out || dut.state !== ref_state)
            $display("FAIL hold: out=%h state=%h expected out=%h state=%h",
                     bus.out, dut.state, last_out, ref_state);
         else passed++;
      end
   endtask

   task automatic test_reset();
      do_reset(64'hDEAD_BEEF_0000_1111, 1'b0);
   endtask

   task automatic test_known_vectors();
      do_reset('0, 1'b0);
      exp_q.push_back(64'hE220A8397B1DCDAF);
      exp_q.push_back(64'h6E789E6AA1B965F4);
      exp_q.push_back(64'h06C45D188009454F);
      for (int unsigned i = 0; i < 3 + PIPE_ZEROS; i++) advance(1'b0, "known_vec");
   endtask

   task automatic test_sequence();
      do_reset(64'h123456789ABCDEF0, 1'b0);
      for (int unsigned i = 0; i < 10; i++) advance(1'b1, "seq");
   endtask

   task automatic test_hold();
      do_reset(64'h0F0F_1234_5678_9ABC, 1'b0);
      for (int unsigned i = 0; i < 4; i++) advance(1'b1, "pre_hold");
      hold(5);
      for (int unsigned i = 0; i < 4; i++) advance(1'b1, "post_hold");
   endtask

   task automatic test_reset_midstream();
      do_reset(64'hAAAA_5555_AAAA_5555, 1'b0);
      for (int unsigned i = 0; i < 4; i++) advance(1'b1, "pre_rst");
      do_reset(64'h0000_0000_CAFE_F00D, 1'b1);
      for (int unsigned i = 0; i < 4; i++) advance(1'b1, "restart");
   endtask

   task automatic test_wrap();
      do_reset(64'hFFFFFFFFFFFFFFFF, 1'b0);
      advance(1'b1, "wrap_out");
      total++;
      if (dut.state !== 64'h9E3779B97F4A7C14)
         $display("FAIL wrap_state: state=%h expected=%h", dut.state, 64'h9E3779B97F4A7C14);
      else passed++;
      for (int unsigned i = 0; i < PIPE_ZEROS; i++) advance(1'b1, "wrap_flush");
   endtask

   task automatic test_back_to_back();
      do_reset(64'h0123_4567_89AB_CDEF, 1'b0);
      for (int unsigned i = 0; i < 12; i++) begin
         advance(1'b1, "b2b");
         if (($urandom() & 3) == 0) hold(1);
      end
   endtask

   initial begin
      bus.en      = 1'b0;
      bus.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_known_vectors();
      test_sequence();
      test_hold();
      test_reset_midstream();
      test_wrap();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
